// File: rtl/smg_pkg.sv
// Shared 7-segment definitions for the display encoder and the capture monitor.
// Patterns are active-low with bit0 = segment a through bit6 = segment g.
package smg_pkg;

  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    HELD
  } smg_state_e;

endpackage

// File: rtl/smg_pattern_lookup.sv
// Combinational inverse of the digit encoder: segment pattern to BCD value plus
// blank/error classification. Value reads 0 for blank and undecodable patterns.
module smg_pattern_lookup
  import smg_pkg::*;
(
  input  logic [6:0] pattern_i,
  output logic [3:0] value_o,
  output logic       is_blank_o,
  output logic       is_error_o
);

  always_comb begin
    value_o    = 4'd0;
    is_blank_o = 1'b0;
    is_error_o = 1'b0;
    case (pattern_i)
      SEG_0:     value_o = 4'd0;
      SEG_1:     value_o = 4'd1;
      SEG_2:     value_o = 4'd2;
      SEG_3:     value_o = 4'd3;
      SEG_4:     value_o = 4'd4;
      SEG_5:     value_o = 4'd5;
      SEG_6:     value_o = 4'd6;
      SEG_7:     value_o = 4'd7;
      SEG_8:     value_o = 4'd8;
      SEG_9:     value_o = 4'd9;
      SEG_BLANK: is_blank_o = 1'b1;
      default:   is_error_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/smg_decode_capture_module.sv
// Multiplexed 7-segment bus monitor: debounces each scan slot, decodes it to BCD and
// holds a per-digit value with valid/blank flags that expire without refresh.
module smg_decode_capture_module
  import smg_pkg::*;
#(
  parameter int unsigned N_DIGITS       = 4,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [6:0]            SMG_Data,
  input  logic [N_DIGITS-1:0]   SMG_Sel,
  output logic [4*N_DIGITS-1:0] Number_Data,
  output logic [N_DIGITS-1:0]   Digit_Valid,
  output logic [N_DIGITS-1:0]   Digit_Blank,
  output logic                  Update_Pulse,
  output logic                  Error_Pulse,
  output logic [N_DIGITS-1:0]   Error_Sel
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES);
  localparam logic [TmoW-1:0] TmoMax  = TmoW'(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  // True when exactly one select line is driven low.
  function automatic logic one_low(input logic [N_DIGITS-1:0] sel);
    logic [N_DIGITS-1:0] lo;
    lo = ~sel;
    return (lo != '0) && ((lo & (lo - 1'b1)) == '0);
  endfunction

  logic [6:0]          s_seg_q;
  logic [N_DIGITS-1:0] s_sel_q;

  smg_state_e          state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [6:0]          ref_seg_q, ref_seg_d;
  logic [N_DIGITS-1:0] ref_sel_q, ref_sel_d;
  logic                accept;

  logic [4*N_DIGITS-1:0] num_q;
  logic [N_DIGITS-1:0]   valid_q, blank_q, err_sel_q;
  logic                  upd_q, err_q;
  logic [TmoW-1:0]       tcnt_q [N_DIGITS];

  logic                legal, same;
  logic [N_DIGITS-1:0] sel_hot;
  logic [3:0]          lk_value;
  logic                lk_blank, lk_error;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s_seg_q <= SEG_BLANK;
      s_sel_q <= '1;
    end else begin
      s_seg_q <= SMG_Data;
      s_sel_q <= SMG_Sel;
    end
  end

  assign legal = one_low(s_sel_q);
  assign same  = (s_seg_q == ref_seg_q) && (s_sel_q == ref_sel_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ref_seg_d = ref_seg_q;
    ref_sel_d = ref_sel_q;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (legal) begin
          state_d   = TRACK;
          cnt_d     = CntW'(1);
          ref_seg_d = s_seg_q;
          ref_sel_d = s_sel_q;
        end
      end
      TRACK: begin
        if (!legal) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (same) begin
          cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        end else begin
          cnt_d     = CntW'(1);
          ref_seg_d = s_seg_q;
          ref_sel_d = s_sel_q;
        end
      end
      HELD: begin
        if (!legal) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (!same) begin
          state_d   = TRACK;
          cnt_d     = CntW'(1);
          ref_seg_d = s_seg_q;
          ref_sel_d = s_sel_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Accept on the edge the run length reaches the threshold, so a single-cycle
    // threshold can accept straight out of IDLE or a reload.
    if (state_d == TRACK && cnt_d == CntMax) begin
      accept  = 1'b1;
      state_d = HELD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ref_seg_q <= SEG_BLANK;
      ref_sel_q <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ref_seg_q <= ref_seg_d;
      ref_sel_q <= ref_sel_d;
    end
  end

  // Decode the pattern being accepted; it always equals the next reference.
  smg_pattern_lookup u_lookup (
    .pattern_i  (ref_seg_d),
    .value_o    (lk_value),
    .is_blank_o (lk_blank),
    .is_error_o (lk_error)
  );

  assign sel_hot = ~ref_sel_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      num_q     <= '0;
      valid_q   <= '0;
      blank_q   <= '0;
      err_sel_q <= '0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) tcnt_q[i] <= '0;
    end else begin
      upd_q <= accept & ~lk_error;
      err_q <= accept & lk_error;
      if (accept && lk_error) err_sel_q <= sel_hot;
      for (int i = 0; i < N_DIGITS; i++) begin
        if (accept && sel_hot[i]) begin
          tcnt_q[i] <= '0;
          if (lk_error) begin
            valid_q[i] <= 1'b0;
            blank_q[i] <= 1'b0;
          end else begin
            num_q[4*i +: 4] <= lk_value;
            valid_q[i]      <= 1'b1;
            blank_q[i]      <= lk_blank;
          end
        end else begin
          if (tcnt_q[i] != TmoMax) tcnt_q[i] <= tcnt_q[i] + 1'b1;
          if (tcnt_q[i] >= TmoLast) begin
            valid_q[i] <= 1'b0;
            blank_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign Number_Data  = num_q;
  assign Digit_Valid  = valid_q;
  assign Digit_Blank  = blank_q;
  assign Update_Pulse = upd_q;
  assign Error_Pulse  = err_q;
  assign Error_Sel    = err_sel_q;

endmodule

// File: tb/tb_smg_decode_capture_module.sv
// Bench for the 7-segment capture monitor: directed scenarios then randomized scan
// traffic, every cycle compared against a run-length / age based reference model.
module tb_smg_decode_capture_module;

  localparam int ND  = 4;
  localparam int STB = 4;
  localparam int TMO = 16;

  logic            CLK;
  logic            RST;
  logic [6:0]      SMG_Data;
  logic [ND-1:0]   SMG_Sel;
  logic [4*ND-1:0] Number_Data;
  logic [ND-1:0]   Digit_Valid;
  logic [ND-1:0]   Digit_Blank;
  logic            Update_Pulse;
  logic            Error_Pulse;
  logic [ND-1:0]   Error_Sel;

  smg_decode_capture_module #(
    .N_DIGITS       (ND),
    .STABLE_CYCLES  (STB),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SMG_Data     (SMG_Data),
    .SMG_Sel      (SMG_Sel),
    .Number_Data  (Number_Data),
    .Digit_Valid  (Digit_Valid),
    .Digit_Blank  (Digit_Blank),
    .Update_Pulse (Update_Pulse),
    .Error_Pulse  (Error_Pulse),
    .Error_Sel    (Error_Sel)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Reference model state
  logic [6:0]    m_samp_seg;
  logic [ND-1:0] m_samp_sel;
  logic [6:0]    run_seg;
  logic [ND-1:0] run_sel;
  int            run_len;
  logic [3:0]    m_num [ND];
  logic [ND-1:0] m_valid, m_blank, m_errsel;
  logic          m_upd, m_err;
  int            m_age [ND];

  int upd_cnt, err_cnt;

  // 0..9 digit, 10 blank, -1 undecodable
  function automatic int dec(input logic [6:0] p);
    if (p == 7'h7F) return 10;
    for (int v = 0; v < 10; v++) if (seg_tbl[v] == p) return v;
    return -1;
  endfunction

  function automatic bit is_legal(input logic [ND-1:0] sel);
    return $countones(~sel) == 1;
  endfunction

  function automatic int low_idx(input logic [ND-1:0] sel);
    for (int d = 0; d < ND; d++) if (!sel[d]) return d;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [6:0] seg, input logic [ND-1:0] sel);
    bit acc;
    int d, v;
    if (rst) begin
      run_len = 0;
      m_valid = '0; m_blank = '0; m_errsel = '0; m_upd = 0; m_err = 0;
      for (int i = 0; i < ND; i++) begin m_num[i] = 0; m_age[i] = 0; end
      m_samp_seg = 7'h7F;
      m_samp_sel = '1;
      return;
    end
    if (is_legal(m_samp_sel)) begin
      if (run_len > 0 && run_seg == m_samp_seg && run_sel == m_samp_sel) run_len++;
      else begin run_seg = m_samp_seg; run_sel = m_samp_sel; run_len = 1; end
    end else run_len = 0;
    acc = (run_len == STB);
    d = low_idx(run_sel);
    v = dec(run_seg);
    m_upd = acc && (v >= 0);
    m_err = acc && (v < 0);
    for (int i = 0; i < ND; i++) begin
      if (acc && i == d) begin
        m_age[i] = 0;
        if (v < 0) begin m_valid[i] = 0; m_blank[i] = 0; end
        else begin
          m_num[i]   = (v == 10) ? 4'd0 : 4'(v);
          m_valid[i] = 1;
          m_blank[i] = (v == 10);
        end
      end else begin
        if (m_age[i] < TMO) m_age[i]++;
        if (m_age[i] >= TMO) begin m_valid[i] = 0; m_blank[i] = 0; end
      end
    end
    if (m_err) m_errsel = ND'(1) << d;
    m_samp_seg = seg;
    m_samp_sel = sel;
  endtask

  task automatic step(input logic [6:0] seg, input logic [ND-1:0] sel, input logic rst);
    logic [4*ND-1:0] exp_num;
    SMG_Data = seg;
    SMG_Sel  = sel;
    RST      = rst;
    @(posedge CLK);
    model_edge(rst, seg, sel);
    #1;
    for (int i = 0; i < ND; i++) exp_num[4*i +: 4] = m_num[i];
    chk("number_data", 32'(Number_Data), 32'(exp_num));
    chk("digit_valid", 32'(Digit_Valid), 32'(m_valid));
    chk("digit_blank", 32'(Digit_Blank), 32'(m_blank));
    chk("update_pulse", 32'(Update_Pulse), 32'(m_upd));
    chk("error_pulse", 32'(Error_Pulse), 32'(m_err));
    chk("error_sel", 32'(Error_Sel), 32'(m_errsel));
    if (Update_Pulse === 1'b1) upd_cnt++;
    if (Error_Pulse === 1'b1) err_cnt++;
  endtask

  initial begin
    logic [6:0]    rseg;
    logic [ND-1:0] rsel;
    int            r, hold;

    RST = 1'b1; SMG_Data = 7'h7F; SMG_Sel = '1;

    // Reset with random inputs
    for (int j = 0; j < 3; j++) step(7'($urandom), ND'($urandom), 1'b1);
    chk("reset_valid", 32'(Digit_Valid), 0);
    chk("reset_num", 32'(Number_Data), 0);
    for (int j = 0; j < 3; j++) step(7'h7F, 4'b1111, 1'b0);
    chk("idle_num", 32'(Number_Data), 0);

    // Digit 0 shows 3: accepted on the fourth edge after first registration
    upd_cnt = 0;
    for (int j = 0; j < 10; j++) begin
      step(7'b011_0000, 4'b1110, 1'b0);
      if (j == 3) chk("latency_early", 32'(Update_Pulse), 0);
      if (j == 4) chk("latency_hit", 32'(Update_Pulse), 1);
    end
    chk("d0_value", 32'(Number_Data[3:0]), 3);
    chk("d0_valid", 32'(Digit_Valid), 32'b0001);
    chk("d0_pulses", upd_cnt, 1);

    // Digit 1: 5 too briefly, then 6 long enough
    upd_cnt = 0;
    for (int j = 0; j < 3; j++) step(7'b001_0010, 4'b1101, 1'b0);
    for (int j = 0; j < 4; j++) step(7'b000_0010, 4'b1101, 1'b0);
    for (int j = 0; j < 3; j++) step(7'h7F, 4'b1111, 1'b0);
    chk("d1_value", 32'(Number_Data[7:4]), 6);
    chk("d1_pulses", upd_cnt, 1);

    // Digit 2: undecodable pattern, then blank
    upd_cnt = 0; err_cnt = 0;
    for (int j = 0; j < 5; j++) step(7'b111_1110, 4'b1011, 1'b0);
    chk("d2_err_pulses", err_cnt, 1);
    chk("d2_err_sel", 32'(Error_Sel), 32'b0100);
    chk("d2_invalid", 32'(Digit_Valid[2]), 0);
    chk("d2_no_update", upd_cnt, 0);
    for (int j = 0; j < 6; j++) step(7'h7F, 4'b1011, 1'b0);
    chk("d2_blank", 32'(Digit_Blank[2]), 1);
    chk("d2_blank_valid", 32'(Digit_Valid[2]), 1);

    // Two selects low: never a legal slot
    upd_cnt = 0; err_cnt = 0;
    for (int j = 0; j < 20; j++) step(7'h00, 4'b1100, 1'b0);
    chk("illegal_pulses", upd_cnt + err_cnt, 0);

    // Reset while tracking at count 3
    for (int j = 0; j < 4; j++) step(7'h00, 4'b0111, 1'b0);
    upd_cnt = 0; err_cnt = 0;
    step(7'h00, 4'b0111, 1'b1);
    for (int j = 0; j < 2; j++) step(7'h00, 4'b0111, 1'b0);
    for (int j = 0; j < 4; j++) step(7'h7F, 4'b1111, 1'b0);
    chk("rst_abort_pulses", upd_cnt + err_cnt, 0);
    chk("rst_abort_valid", 32'(Digit_Valid), 0);

    // Timeout on digit 3: accept 9, then stop scanning
    for (int j = 0; j < 5; j++) step(7'b001_0000, 4'b0111, 1'b0);
    chk("d3_accept", 32'(Digit_Valid[3]), 1);
    for (int j = 0; j < 20; j++) begin
      step(7'h7F, 4'b1111, 1'b0);
      if (j == 14) chk("tmo_before", 32'(Digit_Valid[3]), 1);
      if (j == 15) chk("tmo_at", 32'(Digit_Valid[3]), 0);
    end
    chk("tmo_value_held", 32'(Number_Data[15:12]), 9);

    // Randomized scan traffic
    for (int n = 0; n < 300; n++) begin
      r = int'($urandom_range(0, 12));
      if (r < 10) rseg = seg_tbl[r];
      else if (r == 10) rseg = 7'h7F;
      else rseg = 7'($urandom);
      if ($urandom_range(0, 9) < 8) rsel = ~(ND'(1) << $urandom_range(0, ND - 1));
      else rsel = ND'($urandom);
      hold = int'($urandom_range(1, 7));
      for (int j = 0; j < hold; j++) step(rseg, rsel, 1'b0);
      if ($urandom_range(0, 99) < 3) step(rseg, rsel, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
